// File: rtl/parking_pkg.sv
// Shared types for the multi-gate parking occupancy counter.
// Gate FSM states and the {outer,inner} sensor patterns.
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE,
    IN1,
    IN2,
    IN3,
    OUT1,
    OUT2,
    OUT3,
    WAIT_CLR
  } gate_st_e;

  localparam logic [1:0] P_NONE = 2'b00;
  localparam logic [1:0] P_OUT  = 2'b10;
  localparam logic [1:0] P_BOTH = 2'b11;
  localparam logic [1:0] P_IN   = 2'b01;

endpackage

// File: rtl/parking_occupancy_multi_gate_dir_fsm.sv
// Per-gate direction decoder: entry/exit sequence FSM with
// back-out, illegal-sequence detection and stuck-sensor timeout.
module gate_dir_fsm
  import parking_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] pat,
  output logic       ent_pls,
  output logic       ext_pls,
  output logic       err_pls
);

  localparam bit TO_EN = (TIMEOUT_CYC > 0);
  localparam int TW =
    (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0] TMAX =
    TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  gate_st_e      st_q, st_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          ent_q, ent_d;
  logic          ext_q, ext_d;
  logic          err_q, err_d;
  logic          hold;
  logic          bad;

  always_comb begin
    st_d  = st_q;
    tmr_d = '0;
    ent_d = 1'b0;
    ext_d = 1'b0;
    err_d = 1'b0;
    hold  = 1'b0;
    bad   = 1'b0;
    unique case (st_q)
      IDLE: begin
        unique case (pat)
          P_OUT:   st_d = IN1;
          P_IN:    st_d = OUT1;
          P_NONE:  ;
          default: bad = 1'b1;
        endcase
      end
      IN1: begin
        unique case (pat)
          P_BOTH:  st_d = IN2;
          P_NONE:  st_d = IDLE;
          P_OUT:   hold = 1'b1;
          default: bad = 1'b1;
        endcase
      end
      IN2: begin
        unique case (pat)
          P_IN:    st_d = IN3;
          P_OUT:   st_d = IN1;
          P_BOTH:  hold = 1'b1;
          default: bad = 1'b1;
        endcase
      end
      IN3: begin
        unique case (pat)
          P_NONE: begin
            st_d  = IDLE;
            ent_d = 1'b1;
          end
          P_BOTH:  st_d = IN2;
          P_IN:    hold = 1'b1;
          default: bad = 1'b1;
        endcase
      end
      OUT1: begin
        unique case (pat)
          P_BOTH:  st_d = OUT2;
          P_NONE:  st_d = IDLE;
          P_IN:    hold = 1'b1;
          default: bad = 1'b1;
        endcase
      end
      OUT2: begin
        unique case (pat)
          P_OUT:   st_d = OUT3;
          P_IN:    st_d = OUT1;
          P_BOTH:  hold = 1'b1;
          default: bad = 1'b1;
        endcase
      end
      OUT3: begin
        unique case (pat)
          P_NONE: begin
            st_d  = IDLE;
            ext_d = 1'b1;
          end
          P_BOTH:  st_d = OUT2;
          P_OUT:   hold = 1'b1;
          default: bad = 1'b1;
        endcase
      end
      WAIT_CLR: begin
        if (pat == P_NONE) st_d = IDLE;
      end
    endcase
    // Dwell timer only runs while holding a mid-sequence pattern
    if (hold && TO_EN) begin
      if (tmr_q == TMAX) bad = 1'b1;
      else tmr_d = tmr_q + 1'b1;
    end
    if (bad) begin
      err_d = 1'b1;
      st_d  = WAIT_CLR;
      tmr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= IDLE;
      tmr_q <= '0;
      ent_q <= 1'b0;
      ext_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      tmr_q <= tmr_d;
      ent_q <= ent_d;
      ext_q <= ext_d;
      err_q <= err_d;
    end
  end

  assign ent_pls = ent_q;
  assign ext_pls = ext_q;
  assign err_pls = err_q;

endmodule

// File: rtl/parking_occupancy_multi.sv
// Multi-gate parking occupancy counter: per-gate decoders feed a
// shared saturating count with full/empty and clamp pulses.
module parking_occupancy_multi
  import parking_pkg::*;
#(
  parameter  int NUM_GATES   = 2,
  parameter  int CAPACITY    = 7,
  parameter  int TIMEOUT_CYC = 1000,
  localparam int CNT_W       = $clog2(CAPACITY + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2*NUM_GATES-1:0] sens,
  output logic [NUM_GATES-1:0]   ent_pls,
  output logic [NUM_GATES-1:0]   ext_pls,
  output logic [NUM_GATES-1:0]   err_pls,
  output logic [CNT_W-1:0]       cnt,
  output logic                   full,
  output logic                   empty,
  output logic                   ovf_pls,
  output logic                   udf_pls
);

  localparam int SW = CNT_W + 2;
  localparam logic signed [SW-1:0] CAP_S = SW'(CAPACITY);

  for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
    gate_dir_fsm #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_fsm (
      .clk    (clk),
      .rst    (rst),
      .pat    (sens[2*g+:2]),
      .ent_pls(ent_pls[g]),
      .ext_pls(ext_pls[g]),
      .err_pls(err_pls[g])
    );
  end

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 udf_q, udf_d;
  logic signed [SW-1:0] e_n, x_n, sum;

  // Entries and exits net out before the clamp is applied
  always_comb begin
    e_n = '0;
    x_n = '0;
    for (int g = 0; g < NUM_GATES; g++) begin
      e_n = e_n + SW'(ent_pls[g]);
      x_n = x_n + SW'(ext_pls[g]);
    end
    sum   = $signed({2'b00, cnt_q}) + e_n - x_n;
    cnt_d = sum[CNT_W-1:0];
    ovf_d = 1'b0;
    udf_d = 1'b0;
    if (sum > CAP_S) begin
      cnt_d = CNT_W'(CAPACITY);
      ovf_d = 1'b1;
    end else if (sum < 0) begin
      cnt_d = '0;
      udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign cnt     = cnt_q;
  assign ovf_pls = ovf_q;
  assign udf_pls = udf_q;
  assign full    = (cnt_q == CNT_W'(CAPACITY));
  assign empty   = (cnt_q == '0);

endmodule
